secuenciador_control: RTL and testbench



---
 rtl/secuenciador_control.sv | 161 ++++++++++++++++
 tb/tb_secuenciador_control.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/secuenciador_control.sv
// Multi-cycle FETCH/DECODE/EXEC sequencer for the microcontroller datapath.
// Optional call/ret return-stack control is enabled by defining SUBRUTINAS_EN.
module secuenciador_control #(
  parameter int ANCHO_CNT = 16,
  parameter int PILA_PROF = 4
) (
  input  logic                 reloj,
  input  logic                 reset,
  input  logic [5:0]           opcode,
  input  logic                 mem_ready,
  input  logic                 zero,
  output logic                 fetch_req,
  output logic                 pc_we,
  output logic                 s_inc,
  output logic                 s_inm,
  output logic                 we3,
  output logic                 wez,
  output logic [2:0]           Op,
  output logic                 halt,
  output logic [ANCHO_CNT-1:0] n_instr
`ifdef SUBRUTINAS_EN
  ,
  output logic                 push,
  output logic                 pop,
  output logic                 s_pila,
  output logic                 err_pila
`endif
);

  typedef enum logic [1:0] {
    FETCH, DECODE, EXEC, HALT
  } estado_t;

  estado_t    estado;
  logic [5:0] ir;

  logic       d_inm, d_we3, d_wez;
  logic       d_inc, d_pc, d_fin;
  logic       d_call, d_ret;
  logic [2:0] d_op;
  logic       err;
  logic       ex, dec;

  if (PILA_PROF < 2 || (PILA_PROF & (PILA_PROF - 1)) != 0) begin : g_bad_prof
    $error("PILA_PROF must be a power of 2 and at least 2");
  end

  always_comb begin
    d_inm  = 1'b0;
    d_op   = 3'b000;
    d_we3  = 1'b0;
    d_wez  = 1'b0;
    d_inc  = 1'b1;
    d_pc   = 1'b1;
    d_fin  = 1'b0;
    d_call = 1'b0;
    d_ret  = 1'b0;
    unique case (1'b1)
      ir[5:2] == 4'b0000: begin
        d_inm = 1'b1; d_op = 3'b000;
        d_we3 = 1'b1; d_wez = 1'b1;
      end
      ir[5:2] == 4'b0001: begin
        d_inm = 1'b1; d_op = 3'b010;
        d_we3 = 1'b1; d_wez = 1'b1;
      end
      ir[5:2] == 4'b0010: begin
        d_inm = 1'b1; d_op = 3'b011;
        d_wez = 1'b1;
      end
      ir[5:2] == 4'b0011: begin
        d_inm = 1'b1; d_op = 3'b110;
        d_we3 = 1'b1; d_wez = 1'b1;
      end
      ir[5:2] inside {[4'd4:4'd11]}: begin
        // register ALU group: Op = group - 4, modulo 8
        d_op  = ir[4:2] - 3'd4;
        d_we3 = 1'b1; d_wez = 1'b1;
      end
      ir == 6'b111100: d_inc = 1'b0;
      ir == 6'b111101: d_inc = ~zero;
      ir == 6'b111110: d_inc = zero;
      ir == 6'b111111: begin
        d_pc  = 1'b0;
        d_fin = 1'b1;
      end
`ifdef SUBRUTINAS_EN
      ir == 6'b110000: begin
        d_call = 1'b1;
        d_inc  = 1'b0;
      end
      ir == 6'b110001: d_ret = 1'b1;
`endif
      default: ;
    endcase
  end

`ifdef SUBRUTINAS_EN
  localparam int DW = $clog2(PILA_PROF + 1);

  logic [DW-1:0] depth;
  logic          err_q;

  assign err = (d_call & (depth == DW'(PILA_PROF)))
             | (d_ret & (depth == '0));

  assign push     = ex & d_call & ~err;
  assign pop      = ex & d_ret & ~err;
  assign s_pila   = dec & d_ret;
  assign err_pila = err_q & ~reset;
`else
  assign err = 1'b0;
`endif

  // reset gates outputs immediately so an interrupted EXEC writes nothing
  assign ex  = (estado == EXEC) & ~reset;
  assign dec = ((estado == DECODE) | (estado == EXEC)) & ~reset;

  assign fetch_req = (estado == FETCH) & ~reset;
  assign halt      = (estado == HALT) & ~reset;
  assign pc_we     = ex & d_pc & ~err;
  assign we3       = ex & d_we3;
  assign wez       = ex & d_wez;
  assign s_inc     = dec ? d_inc : 1'b1;
  assign s_inm     = dec & d_inm;
  assign Op        = dec ? d_op : 3'b000;

  always_ff @(posedge reloj) begin
    if (reset) begin
      estado  <= FETCH;
      ir      <= 6'b000000;
      n_instr <= '0;
`ifdef SUBRUTINAS_EN
      depth   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      unique case (estado)
        FETCH: begin
          if (mem_ready) begin
            ir     <= opcode;
            estado <= DECODE;
          end
        end
        DECODE: estado <= EXEC;
        EXEC: begin
          n_instr <= n_instr + ANCHO_CNT'(1);
          estado  <= (d_fin | err) ? HALT : FETCH;
`ifdef SUBRUTINAS_EN
          if (err)         err_q <= 1'b1;
          else if (d_call) depth <= depth + DW'(1);
          else if (d_ret)  depth <= depth - DW'(1);
`endif
        end
        HALT: estado <= HALT;
        default: estado <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_secuenciador_control.sv
// Randomized self-checking bench for secuenciador_control against a decode-table model.
module tb_secuenciador_control;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [5:0]  opcode = 6'b0;
  logic        mem_ready = 1'b0;
  logic        zero = 1'b0;
  logic        fetch_req, pc_we, s_inc, s_inm, we3, wez, halt;
  logic [2:0]  Op;
  logic [15:0] n_instr;
`ifdef SUBRUTINAS_EN
  logic        push, pop, s_pila, err_pila;
  int          dep = 0;
  logic        err_m = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  int n_model = 0;

  typedef struct packed {
    logic       inm;
    logic [2:0] op;
    logic       we3, wez, inc, pcwe, fin;
    logic       push, pop, pila;
  } ctl_t;

  always #5 clk = ~clk;

  secuenciador_control #(.ANCHO_CNT(16), .PILA_PROF(4)) dut (
    .reloj(clk), .reset(reset), .opcode(opcode),
    .mem_ready(mem_ready), .zero(zero),
    .fetch_req(fetch_req), .pc_we(pc_we), .s_inc(s_inc),
    .s_inm(s_inm), .we3(we3), .wez(wez), .Op(Op),
    .halt(halt), .n_instr(n_instr)
`ifdef SUBRUTINAS_EN
    , .push(push), .pop(pop), .s_pila(s_pila), .err_pila(err_pila)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic ctl_t model(input logic [5:0] op, input logic z);
    ctl_t e;
    int g;
    g = int'(op[5:2]);
    e = '0;
    e.inc = 1'b1;
    e.pcwe = 1'b1;
    if (g < 4) begin
      e.inm = 1'b1;
      e.wez = 1'b1;
      e.we3 = (g != 2);
      case (g)
        0: e.op = 3'd0;
        1: e.op = 3'd2;
        2: e.op = 3'd3;
        default: e.op = 3'd6;
      endcase
    end else if (g < 12) begin
      e.op = 3'(g - 4);
      e.we3 = 1'b1;
      e.wez = 1'b1;
    end else if (op == 6'd60) e.inc = 1'b0;
    else if (op == 6'd61) e.inc = ~z;
    else if (op == 6'd62) e.inc = z;
    else if (op == 6'd63) begin
      e.pcwe = 1'b0;
      e.fin = 1'b1;
    end
`ifdef SUBRUTINAS_EN
    if (op == 6'd48) begin
      e.inc = 1'b0;
      if (dep == 4) begin e.pcwe = 1'b0; e.fin = 1'b1; end
      else e.push = 1'b1;
    end else if (op == 6'd49) begin
      e.pila = 1'b1;
      if (dep == 0) begin e.pcwe = 1'b0; e.fin = 1'b1; end
      else e.pop = 1'b1;
    end
`endif
    return e;
  endfunction

  task automatic chk_idle(input string tag);
    chk({tag, ".we3"}, we3, 1'b0);
    chk({tag, ".wez"}, wez, 1'b0);
    chk({tag, ".pc_we"}, pc_we, 1'b0);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    mem_ready = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
      chk("rst.fetch_req", fetch_req, 1'b0);
      chk_idle("rst");
      chk("rst.s_inc", s_inc, 1'b1);
      chk("rst.s_inm", s_inm, 1'b0);
      chk("rst.Op", Op, 3'b000);
      chk("rst.halt", halt, 1'b0);
      chk("rst.n_instr", n_instr, 0);
    end
    reset = 1'b0;
    n_model = 0;
`ifdef SUBRUTINAS_EN
    dep = 0;
    err_m = 1'b0;
`endif
  endtask

  task automatic do_instr(input logic [5:0] op, input logic z,
                          input int nwait);
    ctl_t e;
    e = model(op, z);
    for (int i = 0; i < nwait; i++) begin
      @(negedge clk);
      mem_ready = 1'b0;
      opcode = 6'($urandom_range(63));
      zero = 1'($urandom_range(1));
      #1;
      chk("wait.fetch_req", fetch_req, 1'b1);
      chk_idle("wait");
    end
    @(negedge clk);
    mem_ready = 1'b1;
    opcode = op;
    #1;
    chk("fetch.fetch_req", fetch_req, 1'b1);
    chk("fetch.n_instr", n_instr, n_model);
    chk_idle("fetch");
    @(negedge clk);
    mem_ready = 1'($urandom_range(1));
    opcode = 6'($urandom_range(63));
    zero = z;
    #1;
    chk("dec.fetch_req", fetch_req, 1'b0);
    chk_idle("dec");
    chk("dec.Op", Op, e.op);
    chk("dec.s_inm", s_inm, e.inm);
    @(negedge clk);
    opcode = 6'($urandom_range(63));
    #1;
    chk("ex.Op", Op, e.op);
    chk("ex.s_inm", s_inm, e.inm);
    chk("ex.s_inc", s_inc, e.inc);
    chk("ex.we3", we3, e.we3);
    chk("ex.wez", wez, e.wez);
    chk("ex.pc_we", pc_we, e.pcwe);
    chk("ex.fetch_req", fetch_req, 1'b0);
`ifdef SUBRUTINAS_EN
    chk("ex.push", push, e.push);
    chk("ex.pop", pop, e.pop);
    chk("ex.s_pila", s_pila, e.pila);
    if (e.push) dep++;
    if (e.pop) dep--;
    if (e.fin && op != 6'd63) err_m = 1'b1;
`endif
    n_model = (n_model + 1) % 65536;
  endtask

  task automatic hold_halt(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      mem_ready = 1'($urandom_range(1));
      opcode = 6'($urandom_range(63));
      zero = 1'($urandom_range(1));
      #1;
      chk("halt.halt", halt, 1'b1);
      chk("halt.fetch_req", fetch_req, 1'b0);
      chk_idle("halt");
      chk("halt.n_instr", n_instr, n_model);
`ifdef SUBRUTINAS_EN
      chk("halt.err_pila", err_pila, err_m);
`endif
    end
  endtask

  initial begin
    logic [5:0] rop;

    do_reset(2);
    do_instr(6'b010100, 1'b0, 0);
    do_instr(6'b000100, 1'b1, 5);
    do_instr(6'b111101, 1'b1, 0);
    do_instr(6'b111101, 1'b0, 1);
    do_instr(6'b111110, 1'b1, 0);
    do_instr(6'b111110, 1'b0, 2);
    do_instr(6'b111100, 1'b1, 0);
    do_instr(6'b001000, 1'b0, 0);
    do_instr(6'b101111, 1'b0, 0);

    for (int k = 0; k < 40; k++) begin
      rop = 6'($urandom_range(62));
`ifdef SUBRUTINAS_EN
      if (rop == 6'd48 || rop == 6'd49) rop = 6'd52;
`endif
      do_instr(rop, 1'($urandom_range(1)), int'($urandom_range(3)));
    end

    do_instr(6'b111111, 1'b0, 1);
    hold_halt(20);

    do_reset(1);
    do_instr(6'b001100, 1'b0, 0);

    // abort an instruction in EXEC with reset
    @(negedge clk);
    mem_ready = 1'b1;
    opcode = 6'b011100;
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    chk("abort.dec.Op", Op, 3'd3);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort.we3", we3, 1'b0);
    chk("abort.wez", wez, 1'b0);
    chk("abort.pc_we", pc_we, 1'b0);
    chk("abort.Op", Op, 3'b000);
    chk("abort.s_inc", s_inc, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort.fetch_req", fetch_req, 1'b1);
    chk("abort.n_instr", n_instr, 0);
    n_model = 0;
    do_instr(6'b110010, 1'b0, 0);

`ifdef SUBRUTINAS_EN
    do_reset(1);
    for (int k = 0; k < 5; k++) do_instr(6'b110000, 1'b0, 0);
    hold_halt(3);
    do_reset(1);
    do_instr(6'b110000, 1'b0, 0);
    do_instr(6'b110001, 1'b0, 0);
    do_instr(6'b110001, 1'b0, 0);
    hold_halt(3);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
